alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Front-end initiator for the 2-operand BCD-result ALU.
- Accepts a 3-nibble command frame (op, A, B) over a valid/ready nibble stream and drives registered operands/opcode into the combinational ALU.
- Captures the ALU tens/units/zero/error outputs and returns a 3-nibble response frame over a second valid/ready stream.
- Sits between the pin-level nibble I/O and the ALU core.

Parameters:
- WIDTH, 3, operand width in bits; legal range 2..3 so the product fits the ALU's 6-bit result.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  command nibble valid
- in_ready  output  1  sequencer can accept a command nibble
- in_nib  input  4  command nibble
- out_valid  output  1  response nibble valid
- out_ready  input  1  downstream accepts response nibble
- out_nib  output  4  response nibble
- alu_in1  output  WIDTH  operand A to ALU (registered)
- alu_in2  output  WIDTH  operand B to ALU (registered)
- alu_op  output  2  opcode to ALU: 00 add, 01 sub, 10 mul, 11 div
- alu_dec  input  4  ALU tens digit
- alu_unis  input  4  ALU units digit
- alu_zero  input  1  ALU zero flag
- alu_err  input  1  ALU error flag
- busy  output  1  high whenever state != IDLE
- frame_err  output  1  one-cycle pulse on a malformed command nibble
- done_cnt  output  8  count of response frames fully delivered

Behaviour:
- Reset value of every output and internal register is 0; state = IDLE. Reset is asynchronous.
- Reset mid-frame discards the partial command and any pending response. out_valid drops immediately and is not re-asserted.
- Handshakes:
  - An input transfer occurs on a clk edge with in_valid && in_ready.
  - An output transfer occurs on a clk edge with out_valid && out_ready.
  - in_ready = 1 only in IDLE, GET_A, GET_B; it is combinational from state.
  - out_valid = 1 only in SEND_STAT, SEND_TENS, SEND_UNITS.
  - out_nib is stable while out_valid is high and out_ready is low.
- States and transitions:
  - IDLE: on transfer, if in_nib[3:2] == 00, load alu_op = in_nib[1:0] -> GET_A. Otherwise pulse frame_err, set status = 4'b1000 -> SEND_STAT (error-only response).
  - GET_A: on transfer, if in_nib[3:WIDTH] == 0, load alu_in1 -> GET_B. Otherwise frame_err, status 4'b1000 -> SEND_STAT (error-only).
  - GET_B: same range check; load alu_in2 -> SETTLE. On failure, frame_err, status 4'b1000 -> SEND_STAT (error-only).
  - SETTLE: one cycle for the combinational ALU. At the exiting edge, latch:
    - status = {1'b0, 1'b0, alu_zero, alu_err}
    - tens = alu_dec
    - units = alu_unis
    - then -> SEND_STAT.
  - SEND_STAT: out_nib = status. On transfer: if error-only, -> IDLE and done_cnt += 1; otherwise -> SEND_TENS.
  - SEND_TENS: out_nib = tens. On transfer -> SEND_UNITS.
  - SEND_UNITS: out_nib = units. On transfer -> IDLE, done_cnt += 1.
- Latency: out_valid rises at the 2nd clk edge after the edge that accepts B. It rises at the 1st edge after a malformed nibble.
- Response length: a normal response is exactly 3 nibbles; an error-only response is exactly 1 nibble.
- ALU drive: alu_in1, alu_in2 and alu_op hold their last loaded values in all states. They change only on accepted command nibbles.
- done_cnt wraps 255 -> 0.
- frame_err is high for exactly the cycle after the offending transfer edge.
- No new command is accepted while responding: in_ready = 0, and in_valid is ignored.

Test Plan:
- ADD 5+3: in 0x0, 0x5, 0x3 -> out 0x0, 0x0, 0x8; out_valid rises 2 edges after B accept; done_cnt = 1.
- MUL 7*7: in 0x2, 0x7, 0x7 -> out 0x0, 0x4, 0x9; alu_in1 = alu_in2 = 7 held afterwards.
- SUB 2-5 and DIV 6/0:
  - in 0x1, 0x2, 0x5 -> out 0x3, 0x0, 0x0.
  - in 0x3, 0x6, 0x0 -> out 0x1, 0xF, 0xF.
- Malformed nibbles:
  - first nibble 0x4 -> frame_err one-cycle pulse, single response 0x8, return to IDLE, done_cnt increments.
  - A nibble 0x9 with WIDTH=3 -> same result.
- Backpressure: hold out_ready = 0 for 5 cycles during SEND_TENS -> out_nib stays 0x4 and out_valid stays 1; in_ready = 0 throughout.
- Reset asserted in GET_B mid-frame -> all outputs 0 asynchronously. A subsequent clean frame 0x0, 0x1, 0x1 -> out 0x0, 0x0, 0x2.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - nibble-stream command/response sequencer in front of the BCD ALU
// WIDTH must stay within 2..3 so the largest product fits the ALU's two-digit result.
module alu_cmd_sequencer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_nib,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_nib,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [1:0]       alu_op,
    input  logic [3:0]       alu_dec,
    input  logic [3:0]       alu_unis,
    input  logic             alu_zero,
    input  logic             alu_err,
    output logic             busy,
    output logic             frame_err,
    output logic [7:0]       done_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_SETTLE,
        S_SEND_STAT,
        S_SEND_TENS,
        S_SEND_UNITS
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] in2_q, in2_d;
    logic [3:0]       status_q, status_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       units_q, units_d;
    logic             err_only_q, err_only_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       done_cnt_q, done_cnt_d;

    logic in_xfer;
    logic out_xfer;
    logic operand_ok;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_GET_A) || (state_q == S_GET_B);
    assign out_valid = (state_q == S_SEND_STAT) || (state_q == S_SEND_TENS) ||
                       (state_q == S_SEND_UNITS);
    assign busy      = (state_q != S_IDLE);

    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;
    // Operand nibbles must not carry bits above the operand width.
    assign operand_ok = ((in_nib >> WIDTH) == 4'd0);

    always_comb begin
        out_nib = 4'd0;
        case (state_q)
            S_SEND_STAT:  out_nib = status_q;
            S_SEND_TENS:  out_nib = tens_q;
            S_SEND_UNITS: out_nib = units_q;
            default:      out_nib = 4'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        status_d    = status_q;
        tens_d      = tens_q;
        units_d     = units_q;
        err_only_d  = err_only_q;
        frame_err_d = 1'b0;
        done_cnt_d  = done_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_xfer) begin
                    if (in_nib[3:2] == 2'b00) begin
                        op_d    = in_nib[1:0];
                        state_d = S_GET_A;
                    end else begin
                        frame_err_d = 1'b1;
                        status_d    = 4'b1000;
                        err_only_d  = 1'b1;
                        state_d     = S_SEND_STAT;
                    end
                end
            end
            S_GET_A, S_GET_B: begin
                if (in_xfer) begin
                    if (operand_ok) begin
                        if (state_q == S_GET_A) begin
                            in1_d   = in_nib[WIDTH-1:0];
                            state_d = S_GET_B;
                        end else begin
                            in2_d   = in_nib[WIDTH-1:0];
                            state_d = S_SETTLE;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        status_d    = 4'b1000;
                        err_only_d  = 1'b1;
                        state_d     = S_SEND_STAT;
                    end
                end
            end
            S_SETTLE: begin
                status_d   = {2'b00, alu_zero, alu_err};
                tens_d     = alu_dec;
                units_d    = alu_unis;
                err_only_d = 1'b0;
                state_d    = S_SEND_STAT;
            end
            S_SEND_STAT: begin
                if (out_xfer) begin
                    if (err_only_q) begin
                        done_cnt_d = done_cnt_q + 8'd1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_SEND_TENS;
                    end
                end
            end
            S_SEND_TENS: begin
                if (out_xfer) state_d = S_SEND_UNITS;
            end
            S_SEND_UNITS: begin
                if (out_xfer) begin
                    done_cnt_d = done_cnt_q + 8'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 2'd0;
            in1_q       <= '0;
            in2_q       <= '0;
            status_q    <= 4'd0;
            tens_q      <= 4'd0;
            units_q     <= 4'd0;
            err_only_q  <= 1'b0;
            frame_err_q <= 1'b0;
            done_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            status_q    <= status_d;
            tens_q      <= tens_d;
            units_q     <= units_d;
            err_only_q  <= err_only_d;
            frame_err_q <= frame_err_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign alu_op    = op_q;
    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign frame_err = frame_err_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with a behavioural ALU
module tb_alu_cmd_sequencer;
    localparam int WIDTH = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_nib;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_nib;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [1:0]       alu_op;
    logic [3:0]       alu_dec;
    logic [3:0]       alu_unis;
    logic             alu_zero;
    logic             alu_err;
    logic             busy;
    logic             frame_err;
    logic [7:0]       done_cnt;

    alu_cmd_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_nib(in_nib),
        .out_valid(out_valid), .out_ready(out_ready), .out_nib(out_nib),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_dec(alu_dec), .alu_unis(alu_unis), .alu_zero(alu_zero), .alu_err(alu_err),
        .busy(busy), .frame_err(frame_err), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    logic [1:0]       exp_op;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
    logic [7:0]       exp_done;

    // Expected {status, tens, units} for one operation, from plain arithmetic.
    function automatic logic [11:0] alu_ref(input logic [1:0] op, input int a, input int b);
        int r;
        bit err;
        r = 0;
        err = 1'b0;
        case (op)
            2'd0: r = a + b;
            2'd1: if (a < b) err = 1'b1; else r = a - b;
            2'd2: r = a * b;
            default: if (b == 0) err = 1'b1; else r = a / b;
        endcase
        if (op == 2'd3 && err) return {4'b0001, 4'hF, 4'hF};
        return {2'b00, (r == 0), err, 4'(r / 10), 4'(r % 10)};
    endfunction

    logic [11:0] alu_model;
    always_comb alu_model = alu_ref(alu_op, int'(alu_in1), int'(alu_in2));
    assign alu_dec  = alu_model[7:4];
    assign alu_unis = alu_model[3:0];
    assign alu_zero = alu_model[9];
    assign alu_err  = alu_model[8];

    task automatic send_nib(input logic [3:0] n, output bit ok);
        int t;
        t = 0;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_nib = n;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++; n_mis++;
            $display("FAIL in_ready_timeout: got in_ready=%b want 1", in_ready);
        end else begin
            @(posedge clk);
            #1;
            ok = 1'b1;
        end
        in_valid = 1'b0;
        in_nib = 4'($urandom);
    endtask

    task automatic recv_nib(output logic [3:0] n, input bit stall);
        int t;
        logic [3:0] prev;
        bit hold;
        t = 0;
        hold = 1'b0;
        prev = 4'd0;
        n = 4'd0;
        @(negedge clk);
        forever begin
            if (hold) begin
                n_cmp++;
                if (out_nib !== prev) begin
                    n_mis++;
                    $display("FAIL out_nib_stable: got %h want %h", out_nib, prev);
                end
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) break;
            hold = out_valid;
            prev = out_nib;
            t++;
            if (t > 100) begin
                n_cmp++; n_mis++;
                $display("FAIL out_valid_timeout: got out_valid=%b want 1", out_valid);
                out_ready = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n = out_nib;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic check_idle_after_frame(input string tag);
        n_cmp++;
        if (done_cnt !== exp_done) begin
            n_mis++; $display("FAIL %s done_cnt: got %0d want %0d", tag, done_cnt, exp_done);
        end
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_mis++; $display("FAIL %s idle: got busy=%b out_valid=%b want 0 0", tag, busy, out_valid);
        end
        n_cmp++;
        if (alu_op !== exp_op || alu_in1 !== exp_a || alu_in2 !== exp_b) begin
            n_mis++;
            $display("FAIL %s alu_hold: got op=%0d a=%0d b=%0d want op=%0d a=%0d b=%0d",
                     tag, alu_op, alu_in1, alu_in2, exp_op, exp_a, exp_b);
        end
    endtask

    task automatic run_frame(input logic [1:0] op, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input bit stall, input bit bp,
                             input string tag);
        bit ok;
        logic [3:0] s, te, un;
        logic [11:0] e;
        send_nib({2'b00, op}, ok); if (!ok) return; exp_op = op;
        send_nib(4'(a), ok); if (!ok) return; exp_a = a;
        send_nib(4'(b), ok); if (!ok) return; exp_b = b;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_mis++; $display("FAIL %s settle: got out_valid=%b busy=%b want 0 1", tag, out_valid, busy);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_mis++; $display("FAIL %s latency: got out_valid=%b want 1", tag, out_valid);
        end
        e = alu_ref(op, int'(a), int'(b));
        recv_nib(s, stall);
        n_cmp++;
        if (s !== e[11:8]) begin
            n_mis++; $display("FAIL %s status: got %h want %h", tag, s, e[11:8]);
        end
        if (bp) begin
            in_valid = 1'b1;
            in_nib = 4'h0;
            repeat (5) begin
                @(negedge clk);
                n_cmp++;
                if (out_valid !== 1'b1 || out_nib !== e[7:4] || in_ready !== 1'b0) begin
                    n_mis++;
                    $display("FAIL %s backpressure: got valid=%b nib=%h in_ready=%b want 1 %h 0",
                             tag, out_valid, out_nib, in_ready, e[7:4]);
                end
            end
            in_valid = 1'b0;
        end
        recv_nib(te, stall);
        n_cmp++;
        if (te !== e[7:4]) begin
            n_mis++; $display("FAIL %s tens: got %h want %h", tag, te, e[7:4]);
        end
        recv_nib(un, stall);
        n_cmp++;
        if (un !== e[3:0]) begin
            n_mis++; $display("FAIL %s units: got %h want %h", tag, un, e[3:0]);
        end
        exp_done = exp_done + 8'd1;
        check_idle_after_frame(tag);
    endtask

    task automatic run_bad(input int stage, input logic [3:0] bad, input bit stall, input string tag);
        bit ok;
        logic [3:0] s;
        logic [1:0] op;
        logic [WIDTH-1:0] a;
        if (stage >= 1) begin
            op = 2'($urandom);
            send_nib({2'b00, op}, ok); if (!ok) return; exp_op = op;
        end
        if (stage >= 2) begin
            a = WIDTH'($urandom);
            send_nib(4'(a), ok); if (!ok) return; exp_a = a;
        end
        send_nib(bad, ok); if (!ok) return;
        n_cmp++;
        if (frame_err !== 1'b1 || out_valid !== 1'b1 || out_nib !== 4'h8) begin
            n_mis++;
            $display("FAIL %s err_entry: got frame_err=%b out_valid=%b out_nib=%h want 1 1 8",
                     tag, frame_err, out_valid, out_nib);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_mis++; $display("FAIL %s frame_err_pulse: got %b want 0", tag, frame_err);
        end
        recv_nib(s, stall);
        n_cmp++;
        if (s !== 4'h8) begin
            n_mis++; $display("FAIL %s err_status: got %h want 8", tag, s);
        end
        exp_done = exp_done + 8'd1;
        check_idle_after_frame(tag);
    endtask

    task automatic check_all_zero(input string tag);
        n_cmp++;
        if (out_valid !== 1'b0 || out_nib !== 4'd0 || busy !== 1'b0 || frame_err !== 1'b0 ||
            done_cnt !== 8'd0 || alu_in1 !== '0 || alu_in2 !== '0 || alu_op !== 2'd0) begin
            n_mis++;
            $display("FAIL %s zero: got ov=%b nib=%h busy=%b fe=%b cnt=%0d a=%0d b=%0d op=%0d want all 0",
                     tag, out_valid, out_nib, busy, frame_err, done_cnt, alu_in1, alu_in2, alu_op);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        exp_op = 2'd0; exp_a = '0; exp_b = '0; exp_done = 8'd0;
        @(negedge clk);
    endtask

    task automatic test_add();
        run_frame(2'd0, 3'd5, 3'd3, 1'b0, 1'b0, "add_5_3");
    endtask

    task automatic test_mul_backpressure();
        run_frame(2'd2, 3'd7, 3'd7, 1'b0, 1'b1, "mul_7_7_bp");
    endtask

    task automatic test_sub_div();
        run_frame(2'd1, 3'd2, 3'd5, 1'b0, 1'b0, "sub_2_5");
        run_frame(2'd3, 3'd6, 3'd0, 1'b0, 1'b0, "div_6_0");
    endtask

    task automatic test_malformed();
        run_bad(0, 4'h4, 1'b0, "bad_op");
        run_bad(1, 4'h9, 1'b0, "bad_a");
        run_bad(2, 4'hF, 1'b1, "bad_b");
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        send_nib(4'h2, ok);
        send_nib(4'h3, ok);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("reset_mid_frame");
        @(negedge clk);
        reset = 1'b0;
        exp_op = 2'd0; exp_a = '0; exp_b = '0; exp_done = 8'd0;
        run_frame(2'd0, 3'd1, 3'd1, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        int stage;
        for (int i = 0; i < 260; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                stage = $urandom_range(0, 2);
                run_bad(stage, (stage == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(8, 15)),
                        1'b1, "rand_bad");
            end else begin
                run_frame(2'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'b1, 1'b0, "rand_frame");
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        in_valid = 1'b0;
        in_nib = 4'd0;
        out_ready = 1'b0;
        test_reset();
        test_add();
        test_mul_backpressure();
        test_sub_div();
        test_malformed();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
